riscv_hazard_scoreboard: RTL and testbench
==========================================

# riscv_hazard_scoreboard

Parametrised hazard and forwarding unit for the 5-stage RISC-V pipeline. It generates EX-stage operand forwarding selects and adds a register scoreboard for long-latency writers (loads, multi-cycle mul/div). The scoreboard drives a decode-stage stall for RAW, WAW, load-use and outstanding-limit hazards. Sits between ID/EX control and the pipeline-register enables; replaces the purely combinational forwarding logic.

## Interface

Parameters:
- RF_ADDR_WIDTH, 5, register index width; scoreboard holds 2**RF_ADDR_WIDTH pending bits.
- MAX_OUTSTANDING, 4, maximum in-flight long-latency ops (1..2**RF_ADDR_WIDTH-1).
- CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding counter width (derived; do not override).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs1_id, rs2_id  in  RF_ADDR_WIDTH  source registers of the instruction in ID.
- rs1_used_id, rs2_used_id  in  1  source actually read by the ID instruction.
- rs1_id2ex_ff, rs2_id2ex_ff  in  RF_ADDR_WIDTH  sources of the instruction in EX.
- rd_id2ex_ff  in  RF_ADDR_WIDTH  destination of the instruction in EX.
- mem_read_id2ex_ff  in  1  EX instruction is a load.
- rd_ex2mem_ff, reg_write_ex2mem_ff  in  RF_ADDR_WIDTH, 1  MEM-stage writer.
- rd_mem2wb_ff, reg_write_mem2wb_ff  in  RF_ADDR_WIDTH, 1  WB-stage writer.
- iss_valid  in  1  ID instruction valid.
- iss_long  in  1  ID instruction is a long-latency writer.
- iss_rd  in  RF_ADDR_WIDTH  destination of the ID instruction.
- cmp_valid  in  1  long-latency unit writes back this cycle.
- cmp_rd  in  RF_ADDR_WIDTH  destination of that writeback.
- fwd_a, fwd_b  out  2  EX operand select: 00 RF, 01 MEM/WB, 10 EX/MEM.
- stall  out  1  hold PC and IF/ID, bubble ID/EX.
- sb_busy  out  1  outstanding count non-zero.
- sb_cnt  out  CNT_W  outstanding long-latency ops.
- sb_err  out  1  sticky: completion to a non-pending register.

## Operation

- Forwarding (combinational), per operand:
  - 10 if reg_write_ex2mem_ff, rd_ex2mem_ff!=0 and rd_ex2mem_ff matches the source.
  - Else 01 for the same test on the MEM/WB writer.
  - Else 00. x0 is never forwarded.
- The scoreboard is a pending bit vector. Bit 0 is hard-wired 0.
- issue_fire = iss_valid & iss_long & !stall & iss_rd!=0.
  - Sets pending[iss_rd] at the next edge.
  - Increments sb_cnt.
- cmp_valid with pending[cmp_rd]=1 clears the bit and decrements sb_cnt.
- cmp_valid with pending[cmp_rd]=0 or cmp_rd=0 is ignored and sets sb_err. sb_err clears only on reset.
- Same cycle, same register for issue and completion: pending stays 1 and sb_cnt is unchanged.
- Same cycle, different registers: set and clear both apply; sb_cnt is unchanged.
- stall = iss_valid & (load_use | raw | waw | full):
  - load_use: mem_read_id2ex_ff, rd_id2ex_ff!=0, and rd_id2ex_ff equals a used rs.
  - raw: a used rs has its pending bit set.
  - waw: iss_long and pending[iss_rd].
  - full: iss_long and sb_cnt==MAX_OUTSTANDING.
- sb_cnt never wraps. An increment at MAX_OUTSTANDING is impossible because full stalls the issue.

## Timing

- Reset (rst_n low, asynchronous): pending=0, sb_cnt=0, sb_err=0, sb_busy=0.
  - stall and fwd_a/fwd_b are forced 0 while rst_n is low.
- fwd_a, fwd_b and stall are zero-latency combinational outputs of the current inputs and state.
- A pending bit is visible one cycle after issue_fire.
- Reset asserted mid-operation discards all pending state. Completions arriving after reset release set sb_err.

## Configuration

- RISCV_SB_EARLY_RELEASE_EN defined:
  - A raw or waw match is masked when cmp_valid & cmp_rd equals the matching register in the same cycle.
  - The ID instruction proceeds in the completion cycle; the team's register file is write-through.
- Undefined: the stall is released one cycle later, when the pending bit reads 0.

## Test plan

- Forwarding:
  - EX/MEM writes x5 and MEM/WB writes x5, EX rs1=x5 -> fwd_a=10.
  - Only MEM/WB writes x5 -> fwd_a=01.
  - rd=x0 -> fwd_a=00.
- Load-use: load to x7 in EX, ID uses x7 -> stall=1 one cycle. Load to x7, ID rs2_used_id=0 with rs2=x7 -> stall=0.
- Long op to x3 issued, ID reads x3 -> stall=1 until cmp_rd=x3.
  - Stall drops in the completion cycle with RISCV_SB_EARLY_RELEASE_EN, one cycle later without it.
- MAX_OUTSTANDING=4: issue long ops to x1..x4 -> sb_cnt=4. A fifth long op stalls; one completion -> sb_cnt=3, next cycle stall=0.
- Scoreboard boundary events:
  - Same-cycle issue and completion on x9 -> pending[x9]=1 and sb_cnt unchanged.
  - Completion to non-pending x12 -> sb_err=1, held.
- Reset with sb_cnt=2 mid-operation: all outputs 0 immediately, pending cleared after release.

Source files
------------

// File: rtl/riscv_hazard_scoreboard_if.sv
// Pipeline-side bundle for riscv_hazard_scoreboard: the stage register fields it watches,
// the long-latency issue and completion strobes, and the forwarding, stall and scoreboard outputs.
interface riscv_hazard_scoreboard_if #(
    parameter int RF_ADDR_WIDTH   = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
);
    logic [RF_ADDR_WIDTH-1:0] rs1_id;
    logic [RF_ADDR_WIDTH-1:0] rs2_id;
    logic                     rs1_used_id;
    logic                     rs2_used_id;
    logic [RF_ADDR_WIDTH-1:0] rs1_id2ex_ff;
    logic [RF_ADDR_WIDTH-1:0] rs2_id2ex_ff;
    logic [RF_ADDR_WIDTH-1:0] rd_id2ex_ff;
    logic                     mem_read_id2ex_ff;
    logic [RF_ADDR_WIDTH-1:0] rd_ex2mem_ff;
    logic                     reg_write_ex2mem_ff;
    logic [RF_ADDR_WIDTH-1:0] rd_mem2wb_ff;
    logic                     reg_write_mem2wb_ff;
    logic                     iss_valid;
    logic                     iss_long;
    logic [RF_ADDR_WIDTH-1:0] iss_rd;
    logic                     cmp_valid;
    logic [RF_ADDR_WIDTH-1:0] cmp_rd;
    logic [1:0]               fwd_a;
    logic [1:0]               fwd_b;
    logic                     stall;
    logic                     sb_busy;
    logic [CNT_W-1:0]         sb_cnt;
    logic                     sb_err;

    modport master (
        output rs1_id, rs2_id, rs1_used_id, rs2_used_id,
        output rs1_id2ex_ff, rs2_id2ex_ff, rd_id2ex_ff, mem_read_id2ex_ff,
        output rd_ex2mem_ff, reg_write_ex2mem_ff, rd_mem2wb_ff, reg_write_mem2wb_ff,
        output iss_valid, iss_long, iss_rd, cmp_valid, cmp_rd,
        input  fwd_a, fwd_b, stall, sb_busy, sb_cnt, sb_err
    );

    modport slave (
        input  rs1_id, rs2_id, rs1_used_id, rs2_used_id,
        input  rs1_id2ex_ff, rs2_id2ex_ff, rd_id2ex_ff, mem_read_id2ex_ff,
        input  rd_ex2mem_ff, reg_write_ex2mem_ff, rd_mem2wb_ff, reg_write_mem2wb_ff,
        input  iss_valid, iss_long, iss_rd, cmp_valid, cmp_rd,
        output fwd_a, fwd_b, stall, sb_busy, sb_cnt, sb_err
    );
endinterface

// File: rtl/riscv_hazard_scoreboard.sv
// EX-stage forwarding selects plus a pending-register scoreboard for long-latency writers.
// Optional macro RISCV_SB_EARLY_RELEASE_EN releases RAW/WAW stalls in the completion cycle.
module riscv_hazard_scoreboard #(
    parameter int RF_ADDR_WIDTH   = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    riscv_hazard_scoreboard_if.slave   sb
);
    localparam int NREG = 2 ** RF_ADDR_WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [RF_ADDR_WIDTH-1:0] X0 = {RF_ADDR_WIDTH{1'b0}};

    logic [NREG-1:0]  pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic [1:0] fwd_a_s, fwd_b_s;
    logic       load_use_s, raw_s, waw_s, full_s, hazard_s, stall_s;
    logic       rel_rs1_s, rel_rs2_s, rel_rd_s;
    logic       issue_fire_s, cmp_hit_s, cmp_bad_s;

    // EX/MEM result is younger than MEM/WB, so it wins when both match
    function automatic logic [1:0] fwd_sel(
        input logic [RF_ADDR_WIDTH-1:0] src,
        input logic                     wr_mem,
        input logic [RF_ADDR_WIDTH-1:0] rd_mem,
        input logic                     wr_wb,
        input logic [RF_ADDR_WIDTH-1:0] rd_wb
    );
        logic [1:0] sel;
        if (wr_mem && (rd_mem != X0) && (rd_mem == src)) begin
            sel = 2'b10;
        end else if (wr_wb && (rd_wb != X0) && (rd_wb == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Operand forwarding selects, held at RF while in reset
    always_comb begin
        fwd_a_s = 2'b00;
        fwd_b_s = 2'b00;
        if (rst_n) begin
            fwd_a_s = fwd_sel(sb.rs1_id2ex_ff, sb.reg_write_ex2mem_ff, sb.rd_ex2mem_ff,
                              sb.reg_write_mem2wb_ff, sb.rd_mem2wb_ff);
            fwd_b_s = fwd_sel(sb.rs2_id2ex_ff, sb.reg_write_ex2mem_ff, sb.rd_ex2mem_ff,
                              sb.reg_write_mem2wb_ff, sb.rd_mem2wb_ff);
        end else begin
            fwd_a_s = 2'b00;
            fwd_b_s = 2'b00;
        end
    end

    // A completion landing this cycle can unmask its register (write-through RF)
    always_comb begin
        rel_rs1_s = 1'b0;
        rel_rs2_s = 1'b0;
        rel_rd_s  = 1'b0;
`ifdef RISCV_SB_EARLY_RELEASE_EN
        rel_rs1_s = sb.cmp_valid && (sb.cmp_rd == sb.rs1_id);
        rel_rs2_s = sb.cmp_valid && (sb.cmp_rd == sb.rs2_id);
        rel_rd_s  = sb.cmp_valid && (sb.cmp_rd == sb.iss_rd);
`else
        rel_rs1_s = 1'b0;
        rel_rs2_s = 1'b0;
        rel_rd_s  = 1'b0;
`endif
    end

    // Decode-stage hazard detection and stall
    always_comb begin
        load_use_s = sb.mem_read_id2ex_ff && (sb.rd_id2ex_ff != X0) &&
                     ((sb.rs1_used_id && (sb.rs1_id == sb.rd_id2ex_ff)) ||
                      (sb.rs2_used_id && (sb.rs2_id == sb.rd_id2ex_ff)));
        raw_s      = (sb.rs1_used_id && pending_q[sb.rs1_id] && !rel_rs1_s) ||
                     (sb.rs2_used_id && pending_q[sb.rs2_id] && !rel_rs2_s);
        waw_s      = sb.iss_long && pending_q[sb.iss_rd] && !rel_rd_s;
        full_s     = sb.iss_long && (cnt_q == CNT_MAX);
        hazard_s   = sb.iss_valid && (load_use_s || raw_s || waw_s || full_s);
        stall_s    = rst_n && hazard_s;
    end

    // Scoreboard next state: clear before set so a same-register pair stays pending
    always_comb begin
        issue_fire_s = sb.iss_valid && sb.iss_long && !hazard_s && (sb.iss_rd != X0);
        cmp_hit_s    = sb.cmp_valid && (sb.cmp_rd != X0) && pending_q[sb.cmp_rd];
        cmp_bad_s    = sb.cmp_valid && !cmp_hit_s;
        pending_d    = pending_q;
        if (cmp_hit_s) begin
            pending_d[sb.cmp_rd] = 1'b0;
        end else begin
            pending_d = pending_d;
        end
        if (issue_fire_s) begin
            pending_d[sb.iss_rd] = 1'b1;
        end else begin
            pending_d = pending_d;
        end
        pending_d[0] = 1'b0;
        case ({issue_fire_s, cmp_hit_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        busy_d = (cnt_d != {CNT_W{1'b0}});
        err_d  = err_q || cmp_bad_s;
    end

    // Scoreboard state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= {NREG{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign sb.fwd_a   = fwd_a_s;
    assign sb.fwd_b   = fwd_b_s;
    assign sb.stall   = stall_s;
    assign sb.sb_busy = busy_q;
    assign sb.sb_cnt  = cnt_q;
    assign sb.sb_err  = err_q;
endmodule

// File: tb/tb_riscv_hazard_scoreboard.sv
// Directed-vector bench for riscv_hazard_scoreboard; expectations follow the early-release macro.
module tb_riscv_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    riscv_hazard_scoreboard_if #(.RF_ADDR_WIDTH(5), .MAX_OUTSTANDING(4)) sbif ();

    riscv_hazard_scoreboard #(.RF_ADDR_WIDTH(5), .MAX_OUTSTANDING(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sbif.slave)
    );

    always #5 clk = ~clk;

    task automatic idle();
        sbif.rs1_id = 5'd0; sbif.rs2_id = 5'd0;
        sbif.rs1_used_id = 1'b0; sbif.rs2_used_id = 1'b0;
        sbif.rs1_id2ex_ff = 5'd0; sbif.rs2_id2ex_ff = 5'd0;
        sbif.rd_id2ex_ff = 5'd0; sbif.mem_read_id2ex_ff = 1'b0;
        sbif.rd_ex2mem_ff = 5'd0; sbif.reg_write_ex2mem_ff = 1'b0;
        sbif.rd_mem2wb_ff = 5'd0; sbif.reg_write_mem2wb_ff = 1'b0;
        sbif.iss_valid = 1'b0; sbif.iss_long = 1'b0; sbif.iss_rd = 5'd0;
        sbif.cmp_valid = 1'b0; sbif.cmp_rd = 5'd0;
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        idle();
        sbif.iss_valid = 1'b1; sbif.iss_long = 1'b1; sbif.iss_rd = rd;
        step();
    endtask

    task automatic complete(input logic [4:0] rd);
        idle();
        sbif.cmp_valid = 1'b1; sbif.cmp_rd = rd;
        step();
    endtask

    task automatic test_reset();
        idle();
        sbif.reg_write_ex2mem_ff = 1'b1; sbif.rd_ex2mem_ff = 5'd5; sbif.rs1_id2ex_ff = 5'd5;
        sbif.mem_read_id2ex_ff = 1'b1; sbif.rd_id2ex_ff = 5'd7;
        sbif.iss_valid = 1'b1; sbif.rs1_id = 5'd7; sbif.rs1_used_id = 1'b1;
        #12;
        vec_cnt++; if (sbif.fwd_a !== 2'b00) begin err_cnt++; $display("FAIL reset_fwd_a got %b want 00", sbif.fwd_a); end
        vec_cnt++; if (sbif.stall !== 1'b0) begin err_cnt++; $display("FAIL reset_stall got %b want 0", sbif.stall); end
        vec_cnt++; if (sbif.sb_cnt !== 3'd0 || sbif.sb_busy !== 1'b0 || sbif.sb_err !== 1'b0) begin
            err_cnt++; $display("FAIL reset_state got cnt=%0d busy=%b err=%b want 0/0/0", sbif.sb_cnt, sbif.sb_busy, sbif.sb_err); end
        idle();
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic test_forwarding();
        idle();
        sbif.reg_write_ex2mem_ff = 1'b1; sbif.rd_ex2mem_ff = 5'd5;
        sbif.reg_write_mem2wb_ff = 1'b1; sbif.rd_mem2wb_ff = 5'd5;
        sbif.rs1_id2ex_ff = 5'd5; sbif.rs2_id2ex_ff = 5'd6;
        #1;
        vec_cnt++; if (sbif.fwd_a !== 2'b10) begin err_cnt++; $display("FAIL fwd_both_a got %b want 10", sbif.fwd_a); end
        vec_cnt++; if (sbif.fwd_b !== 2'b00) begin err_cnt++; $display("FAIL fwd_both_b got %b want 00", sbif.fwd_b); end
        sbif.reg_write_ex2mem_ff = 1'b0; sbif.rs2_id2ex_ff = 5'd5;
        #1;
        vec_cnt++; if (sbif.fwd_a !== 2'b01) begin err_cnt++; $display("FAIL fwd_wb_a got %b want 01", sbif.fwd_a); end
        vec_cnt++; if (sbif.fwd_b !== 2'b01) begin err_cnt++; $display("FAIL fwd_wb_b got %b want 01", sbif.fwd_b); end
        sbif.reg_write_ex2mem_ff = 1'b1; sbif.rd_ex2mem_ff = 5'd0; sbif.rd_mem2wb_ff = 5'd0;
        sbif.rs1_id2ex_ff = 5'd0; sbif.rs2_id2ex_ff = 5'd0;
        #1;
        vec_cnt++; if (sbif.fwd_a !== 2'b00) begin err_cnt++; $display("FAIL fwd_x0_a got %b want 00", sbif.fwd_a); end
        sbif.rd_ex2mem_ff = 5'd9; sbif.rs2_id2ex_ff = 5'd9;
        #1;
        vec_cnt++; if (sbif.fwd_b !== 2'b10) begin err_cnt++; $display("FAIL fwd_mem_b got %b want 10", sbif.fwd_b); end
        step();
    endtask

    task automatic test_load_use();
        idle();
        sbif.mem_read_id2ex_ff = 1'b1; sbif.rd_id2ex_ff = 5'd7;
        sbif.iss_valid = 1'b1; sbif.rs1_id = 5'd7; sbif.rs1_used_id = 1'b1;
        #1;
        vec_cnt++; if (sbif.stall !== 1'b1) begin err_cnt++; $display("FAIL load_use_rs1 got %b want 1", sbif.stall); end
        sbif.rs1_id = 5'd2; sbif.rs2_id = 5'd7; sbif.rs2_used_id = 1'b0;
        #1;
        vec_cnt++; if (sbif.stall !== 1'b0) begin err_cnt++; $display("FAIL load_use_unused got %b want 0", sbif.stall); end
        sbif.rs2_used_id = 1'b1;
        #1;
        vec_cnt++; if (sbif.stall !== 1'b1) begin err_cnt++; $display("FAIL load_use_rs2 got %b want 1", sbif.stall); end
        // Bubble inserted: load has moved on, same ID instruction proceeds
        step();
        sbif.mem_read_id2ex_ff = 1'b0; sbif.rd_id2ex_ff = 5'd0;
        #1;
        vec_cnt++; if (sbif.stall !== 1'b0) begin err_cnt++; $display("FAIL load_use_release got %b want 0", sbif.stall); end
        step();
    endtask

    task automatic test_long_raw();
        idle();
        sbif.iss_valid = 1'b1; sbif.iss_long = 1'b1; sbif.iss_rd = 5'd3;
        #1;
        vec_cnt++; if (sbif.stall !== 1'b0) begin err_cnt++; $display("FAIL long_issue_stall got %b want 0", sbif.stall); end
        step();
        idle();
        sbif.iss_valid = 1'b1; sbif.rs1_id = 5'd3; sbif.rs1_used_id = 1'b1;
        #1;
        vec_cnt++; if (sbif.stall !== 1'b1) begin err_cnt++; $display("FAIL raw_stall got %b want 1", sbif.stall); end
        vec_cnt++; if (sbif.sb_cnt !== 3'd1 || sbif.sb_busy !== 1'b1) begin
            err_cnt++; $display("FAIL raw_cnt got cnt=%0d busy=%b want 1/1", sbif.sb_cnt, sbif.sb_busy); end
        step();
        vec_cnt++; if (sbif.stall !== 1'b1) begin err_cnt++; $display("FAIL raw_hold got %b want 1", sbif.stall); end
        sbif.cmp_valid = 1'b1; sbif.cmp_rd = 5'd3;
        #1;
`ifdef RISCV_SB_EARLY_RELEASE_EN
        vec_cnt++; if (sbif.stall !== 1'b0) begin err_cnt++; $display("FAIL raw_cmp_cycle got %b want 0", sbif.stall); end
`else
        vec_cnt++; if (sbif.stall !== 1'b1) begin err_cnt++; $display("FAIL raw_cmp_cycle got %b want 1", sbif.stall); end
`endif
        step();
        sbif.cmp_valid = 1'b0;
        #1;
        vec_cnt++; if (sbif.stall !== 1'b0) begin err_cnt++; $display("FAIL raw_after_cmp got %b want 0", sbif.stall); end
        vec_cnt++; if (sbif.sb_cnt !== 3'd0 || sbif.sb_busy !== 1'b0) begin
            err_cnt++; $display("FAIL raw_cnt_after got cnt=%0d busy=%b want 0/0", sbif.sb_cnt, sbif.sb_busy); end
        step();
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) begin
            idle();
            sbif.iss_valid = 1'b1; sbif.iss_long = 1'b1; sbif.iss_rd = 5'(i);
            #1;
            vec_cnt++; if (sbif.stall !== 1'b0) begin err_cnt++; $display("FAIL full_fill%0d got %b want 0", i, sbif.stall); end
            step();
        end
        vec_cnt++; if (sbif.sb_cnt !== 3'd4) begin err_cnt++; $display("FAIL full_cnt got %0d want 4", sbif.sb_cnt); end
        sbif.iss_rd = 5'd5; sbif.cmp_valid = 1'b1; sbif.cmp_rd = 5'd1;
        #1;
        vec_cnt++; if (sbif.stall !== 1'b1) begin err_cnt++; $display("FAIL full_stall got %b want 1", sbif.stall); end
        step();
        sbif.cmp_valid = 1'b0;
        #1;
        vec_cnt++; if (sbif.sb_cnt !== 3'd3) begin err_cnt++; $display("FAIL full_drain_cnt got %0d want 3", sbif.sb_cnt); end
        vec_cnt++; if (sbif.stall !== 1'b0) begin err_cnt++; $display("FAIL full_release got %b want 0", sbif.stall); end
        step();
        vec_cnt++; if (sbif.sb_cnt !== 3'd4) begin err_cnt++; $display("FAIL full_refill got %0d want 4", sbif.sb_cnt); end
        for (int i = 2; i <= 5; i++) complete(5'(i));
        vec_cnt++; if (sbif.sb_cnt !== 3'd0 || sbif.sb_err !== 1'b0) begin
            err_cnt++; $display("FAIL full_empty got cnt=%0d err=%b want 0/0", sbif.sb_cnt, sbif.sb_err); end
    endtask

    task automatic test_same_cycle();
        issue(5'd9);
        idle();
        sbif.iss_valid = 1'b1; sbif.iss_long = 1'b1; sbif.iss_rd = 5'd9;
        sbif.cmp_valid = 1'b1; sbif.cmp_rd = 5'd9;
        #1;
`ifdef RISCV_SB_EARLY_RELEASE_EN
        vec_cnt++; if (sbif.stall !== 1'b0) begin err_cnt++; $display("FAIL same_reg_stall got %b want 0", sbif.stall); end
        step();
        idle();
        sbif.iss_valid = 1'b1; sbif.rs1_id = 5'd9; sbif.rs1_used_id = 1'b1;
        #1;
        vec_cnt++; if (sbif.sb_cnt !== 3'd1) begin err_cnt++; $display("FAIL same_reg_cnt got %0d want 1", sbif.sb_cnt); end
        vec_cnt++; if (sbif.stall !== 1'b1) begin err_cnt++; $display("FAIL same_reg_pending got %b want 1", sbif.stall); end
        complete(5'd9);
`else
        vec_cnt++; if (sbif.stall !== 1'b1) begin err_cnt++; $display("FAIL same_reg_stall got %b want 1", sbif.stall); end
        step();
        idle();
        sbif.iss_valid = 1'b1; sbif.rs1_id = 5'd9; sbif.rs1_used_id = 1'b1;
        #1;
        vec_cnt++; if (sbif.sb_cnt !== 3'd0) begin err_cnt++; $display("FAIL same_reg_cnt got %0d want 0", sbif.sb_cnt); end
        vec_cnt++; if (sbif.stall !== 1'b0) begin err_cnt++; $display("FAIL same_reg_pending got %b want 0", sbif.stall); end
`endif
        issue(5'd11);
        idle();
        sbif.iss_valid = 1'b1; sbif.iss_long = 1'b1; sbif.iss_rd = 5'd13;
        sbif.cmp_valid = 1'b1; sbif.cmp_rd = 5'd11;
        step();
        idle();
        sbif.iss_valid = 1'b1; sbif.rs1_id = 5'd13; sbif.rs1_used_id = 1'b1;
        sbif.rs2_id = 5'd11; sbif.rs2_used_id = 1'b0;
        #1;
        vec_cnt++; if (sbif.sb_cnt !== 3'd1) begin err_cnt++; $display("FAIL diff_reg_cnt got %0d want 1", sbif.sb_cnt); end
        vec_cnt++; if (sbif.stall !== 1'b1) begin err_cnt++; $display("FAIL diff_reg_set got %b want 1", sbif.stall); end
        sbif.rs1_used_id = 1'b0; sbif.rs2_used_id = 1'b1;
        #1;
        vec_cnt++; if (sbif.stall !== 1'b0) begin err_cnt++; $display("FAIL diff_reg_clear got %b want 0", sbif.stall); end
        complete(5'd13);
        vec_cnt++; if (sbif.sb_cnt !== 3'd0 || sbif.sb_err !== 1'b0) begin
            err_cnt++; $display("FAIL same_cycle_end got cnt=%0d err=%b want 0/0", sbif.sb_cnt, sbif.sb_err); end
    endtask

    task automatic test_err();
        complete(5'd12);
        vec_cnt++; if (sbif.sb_err !== 1'b1) begin err_cnt++; $display("FAIL err_set got %b want 1", sbif.sb_err); end
        vec_cnt++; if (sbif.sb_cnt !== 3'd0) begin err_cnt++; $display("FAIL err_cnt got %0d want 0", sbif.sb_cnt); end
        idle();
        step(); step(); step();
        vec_cnt++; if (sbif.sb_err !== 1'b1) begin err_cnt++; $display("FAIL err_sticky got %b want 1", sbif.sb_err); end
    endtask

    task automatic test_reset_mid();
        issue(5'd1);
        issue(5'd2);
        vec_cnt++; if (sbif.sb_cnt !== 3'd2) begin err_cnt++; $display("FAIL mid_cnt_pre got %0d want 2", sbif.sb_cnt); end
        sbif.iss_valid = 1'b1; sbif.iss_long = 1'b0;
        sbif.rs1_id = 5'd1; sbif.rs1_used_id = 1'b1;
        sbif.reg_write_ex2mem_ff = 1'b1; sbif.rd_ex2mem_ff = 5'd4; sbif.rs1_id2ex_ff = 5'd4;
        #2 rst_n = 1'b0;
        #1;
        vec_cnt++; if (sbif.sb_cnt !== 3'd0 || sbif.sb_busy !== 1'b0 || sbif.sb_err !== 1'b0) begin
            err_cnt++; $display("FAIL mid_state got cnt=%0d busy=%b err=%b want 0/0/0", sbif.sb_cnt, sbif.sb_busy, sbif.sb_err); end
        vec_cnt++; if (sbif.stall !== 1'b0 || sbif.fwd_a !== 2'b00) begin
            err_cnt++; $display("FAIL mid_comb got stall=%b fwd_a=%b want 0/00", sbif.stall, sbif.fwd_a); end
        #3 rst_n = 1'b1;
        #1;
        vec_cnt++; if (sbif.stall !== 1'b0) begin err_cnt++; $display("FAIL mid_pending_cleared got %b want 0", sbif.stall); end
        vec_cnt++; if (sbif.fwd_a !== 2'b10) begin err_cnt++; $display("FAIL mid_fwd_back got %b want 10", sbif.fwd_a); end
        step();
        complete(5'd2);
        vec_cnt++; if (sbif.sb_err !== 1'b1 || sbif.sb_cnt !== 3'd0) begin
            err_cnt++; $display("FAIL mid_stale_cmp got err=%b cnt=%0d want 1/0", sbif.sb_err, sbif.sb_cnt); end
    endtask

    initial begin
        idle();
        test_reset();
        test_forwarding();
        test_load_use();
        test_long_raw();
        test_full();
        test_same_cycle();
        test_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
